// File: rtl/sha256_round_sequencer.sv
// Iterative SHA-256 compression controller: one round per clock, sliding
// 16-word message schedule, final chaining addition and a held digest output.
module sha256_round_sequencer #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [0:511] i_block_in,
  input  logic [0:255] i_hash_in,
  input  logic         i_abort,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [0:255] o_digest_out,
  output logic         o_busy,
  output logic [5:0]   o_round_idx
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_ADD   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [5:0] LP_LAST_ROUND = 6'(NUM_ROUNDS - 1);

  function automatic logic [31:0] choice(input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] majority(input logic [31:0] x, input logic [31:0] y,
                                           input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

  function automatic logic [31:0] k_rom(input logic [5:0] idx);
    logic [31:0] k;
    case (idx)
      6'd0:  k = 32'h428a2f98;
      6'd1:  k = 32'h71374491;
      6'd2:  k = 32'hb5c0fbcf;
      6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;
      6'd5:  k = 32'h59f111f1;
      6'd6:  k = 32'h923f82a4;
      6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;
      6'd9:  k = 32'h12835b01;
      6'd10: k = 32'h243185be;
      6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;
      6'd13: k = 32'h80deb1fe;
      6'd14: k = 32'h9bdc06a7;
      6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;
      6'd17: k = 32'hefbe4786;
      6'd18: k = 32'h0fc19dc6;
      6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;
      6'd21: k = 32'h4a7484aa;
      6'd22: k = 32'h5cb0a9dc;
      6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;
      6'd25: k = 32'ha831c66d;
      6'd26: k = 32'hb00327c8;
      6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;
      6'd29: k = 32'hd5a79147;
      6'd30: k = 32'h06ca6351;
      6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;
      6'd33: k = 32'h2e1b2138;
      6'd34: k = 32'h4d2c6dfc;
      6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;
      6'd37: k = 32'h766a0abb;
      6'd38: k = 32'h81c2c92e;
      6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;
      6'd41: k = 32'ha81a664b;
      6'd42: k = 32'hc24b8b70;
      6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;
      6'd45: k = 32'hd6990624;
      6'd46: k = 32'hf40e3585;
      6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;
      6'd49: k = 32'h1e376c08;
      6'd50: k = 32'h2748774c;
      6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;
      6'd53: k = 32'h4ed8aa4a;
      6'd54: k = 32'h5b9cca4f;
      6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;
      6'd57: k = 32'h78a5636f;
      6'd58: k = 32'h84c87814;
      6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;
      6'd61: k = 32'ha4506ceb;
      6'd62: k = 32'hbef9a3f7;
      6'd63: k = 32'hc67178f2;
      default: k = 32'h00000000;
    endcase
    return k;
  endfunction

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_busy;
  logic [5:0]   r_round_idx;
  logic [0:255] r_digest;
  logic [31:0]  r_h  [0:7];
  logic [31:0]  r_wk [0:7];
  logic [31:0]  r_w  [0:15];

  logic         w_accept;
  logic         w_do_round;
  logic         w_do_add;
  logic         w_last_round;
  logic         w_in_ready_nxt;
  logic         w_out_valid_nxt;
  logic         w_busy_nxt;
  logic [31:0]  w_t1;
  logic [31:0]  w_t2;
  logic [31:0]  w_w_next;

  assign w_last_round = (r_round_idx == LP_LAST_ROUND);

  // Next-state and next-output decode; abort outranks every ROUND/ADD exit.
  always_comb begin
    w_state_nxt     = r_state;
    w_accept        = 1'b0;
    w_do_round      = 1'b0;
    w_do_add        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_in_valid && r_in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ROUND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ROUND: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last_round) begin
          w_do_round  = 1'b1;
          w_state_nxt = ST_ADD;
        end else begin
          w_do_round  = 1'b1;
          w_state_nxt = ST_ROUND;
        end
      end
      ST_ADD: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_do_add    = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (r_out_valid && i_out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_in_ready_nxt  = (w_state_nxt == ST_IDLE);
    w_out_valid_nxt = (w_state_nxt == ST_DONE);
    w_busy_nxt      = (w_state_nxt == ST_ROUND) || (w_state_nxt == ST_ADD);
  end

  // State register and registered handshake/status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // One compression round plus the next schedule word; index 0..7 is a..h.
  always_comb begin
    w_t1     = r_wk[7] + big_sigma1(r_wk[4]) + choice(r_wk[4], r_wk[5], r_wk[6])
             + k_rom(r_round_idx) + r_w[0];
    w_t2     = big_sigma0(r_wk[0]) + majority(r_wk[0], r_wk[1], r_wk[2]);
    w_w_next = small_sigma1(r_w[14]) + r_w[9] + small_sigma0(r_w[1]) + r_w[0];
  end

  // Datapath registers: block capture, round update, chaining addition.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_h[i]  <= 32'h00000000;
        r_wk[i] <= 32'h00000000;
      end
      for (int i = 0; i < 16; i++) begin
        r_w[i] <= 32'h00000000;
      end
      r_round_idx <= 6'd0;
      r_digest    <= 256'h0;
    end else if (w_accept) begin
      for (int i = 0; i < 8; i++) begin
        r_h[i]  <= i_hash_in[32*i +: 32];
        r_wk[i] <= i_hash_in[32*i +: 32];
      end
      for (int i = 0; i < 16; i++) begin
        r_w[i] <= i_block_in[32*i +: 32];
      end
      r_round_idx <= 6'd0;
    end else if (w_do_round) begin
      r_wk[0] <= w_t1 + w_t2;
      r_wk[1] <= r_wk[0];
      r_wk[2] <= r_wk[1];
      r_wk[3] <= r_wk[2];
      r_wk[4] <= r_wk[3] + w_t1;
      r_wk[5] <= r_wk[4];
      r_wk[6] <= r_wk[5];
      r_wk[7] <= r_wk[6];
      for (int i = 0; i < 15; i++) begin
        r_w[i] <= r_w[i+1];
      end
      r_w[15] <= w_w_next;
      // The counter parks on the last round so debug sees where it finished.
      if (!w_last_round) begin
        r_round_idx <= r_round_idx + 6'd1;
      end
    end else if (w_do_add) begin
      for (int i = 0; i < 8; i++) begin
        r_digest[32*i +: 32] <= r_h[i] + r_wk[i];
      end
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_out_valid  = r_out_valid;
  assign o_busy       = r_busy;
  assign o_round_idx  = r_round_idx;
  assign o_digest_out = r_digest;

endmodule

// File: tb/tb_sha256_round_sequencer.sv
// Self-checking bench for sha256_round_sequencer: known vectors, handshake and
// abort/reset timing, plus random blocks checked against a plain SHA-256 model.
module tb_sha256_round_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [0:511] block_in;
  logic [0:255] hash_in;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [0:255] digest_out;
  logic         busy;
  logic [5:0]   round_idx;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [0:255] H_INIT =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [0:511] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [0:511] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [0:511] BLK_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [0:511] BLK_TWO2  = {480'h0, 32'h000001c0};
  localparam logic [0:255] DIG_ABC   =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [0:255] DIG_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [0:255] DIG_TWO   =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] K_TAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  sha256_round_sequencer #(.NUM_ROUNDS(64)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_block_in(block_in), .i_hash_in(hash_in), .i_abort(abort),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_digest_out(digest_out),
    .o_busy(busy), .o_round_idx(round_idx));

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference: full 64-entry schedule expanded up front, then 64 rounds.
  function automatic logic [0:255] ref_compress(input logic [0:255] hv, input logic [0:511] blk);
    logic [31:0]  w [0:63];
    logic [31:0]  v [0:7];
    logic [31:0]  t1, t2, s0, s1;
    logic [0:255] r;
    for (int t = 0; t < 16; t++) w[t] = blk[32*t +: 32];
    for (int t = 16; t < 64; t++) begin
      s0   = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1   = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hv[32*i +: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TAB[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[32*i +: 32] = hv[32*i +: 32] + v[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the accept edge (edge 0); ok=0 if in_ready never came.
  task automatic send_block(input logic [0:511] blk, input logic [0:255] hv, output bit ok);
    ok       = 1'b0;
    block_in = blk;
    hash_in  = hv;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready === 1'b1) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input int limit, output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic release_digest();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (round_idx !== 6'd0) $display("FAIL rst_round_idx: got %0d want 0", round_idx); else n_pass++;
    n_checks++; if (digest_out !== 256'h0) $display("FAIL rst_digest: got %h want 0", digest_out); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL release_ready_early: got %b want 0", in_ready); else n_pass++;
    tick();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL release_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_abc();
    bit ok; int n;
    send_block(BLK_ABC, H_INIT, ok);
    n_checks++; if (!ok) $display("FAIL abc_accept: got timeout want accept"); else n_pass++;
    n_checks++; if ({busy, in_ready} !== 2'b10) $display("FAIL abc_accept_edge: got busy/ready %b want 10", {busy, in_ready}); else n_pass++;
    wait_out_valid(200, n);
    n_checks++; if (n != 65) $display("FAIL abc_latency: got %0d want 65", n); else n_pass++;
    n_checks++; if (digest_out !== DIG_ABC) $display("FAIL abc_digest: got %h want %h", digest_out, DIG_ABC); else n_pass++;
    n_checks++; if (digest_out !== ref_compress(H_INIT, BLK_ABC)) $display("FAIL abc_model: got %h want %h", digest_out, ref_compress(H_INIT, BLK_ABC)); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL abc_busy_done: got %b want 0", busy); else n_pass++;
    n_checks++; if (round_idx !== 6'd63) $display("FAIL abc_round_hold: got %0d want 63", round_idx); else n_pass++;
    release_digest();
    n_checks++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL abc_release: got valid/ready %b want 01", {out_valid, in_ready}); else n_pass++;
  endtask

  task automatic test_empty();
    bit ok; int n;
    send_block(BLK_EMPTY, H_INIT, ok);
    wait_out_valid(200, n);
    n_checks++; if (!ok || n != 65) $display("FAIL empty_latency: got ok=%b n=%0d want ok=1 n=65", ok, n); else n_pass++;
    n_checks++; if (digest_out !== DIG_EMPTY) $display("FAIL empty_digest: got %h want %h", digest_out, DIG_EMPTY); else n_pass++;
    release_digest();
  endtask

  task automatic test_reset_midround();
    bit ok; int n;
    send_block(BLK_ABC, H_INIT, ok);
    repeat (30) tick();
    n_checks++; if (round_idx !== 6'd30) $display("FAIL mid_round_idx: got %0d want 30", round_idx); else n_pass++;
    rst_n = 1'b0;
    #2;
    n_checks++; if ({in_ready, out_valid, busy} !== 3'b000) $display("FAIL mid_rst_flags: got %b want 000", {in_ready, out_valid, busy}); else n_pass++;
    n_checks++; if (round_idx !== 6'd0) $display("FAIL mid_rst_idx: got %0d want 0", round_idx); else n_pass++;
    n_checks++; if (digest_out !== 256'h0) $display("FAIL mid_rst_digest: got %h want 0", digest_out); else n_pass++;
    tick();
    rst_n = 1'b1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL mid_release_early: got %b want 0", in_ready); else n_pass++;
    tick();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL mid_release_ready: got %b want 1", in_ready); else n_pass++;
    send_block(BLK_ABC, H_INIT, ok);
    wait_out_valid(200, n);
    n_checks++; if (digest_out !== DIG_ABC || n != 65) $display("FAIL mid_fresh_abc: got %h n=%0d want %h n=65", digest_out, n, DIG_ABC); else n_pass++;
    release_digest();
  endtask

  task automatic test_back_pressure();
    bit ok; int n; int n_unstable; int n_ready; int n_vlow;
    n_unstable = 0; n_ready = 0; n_vlow = 0;
    send_block(BLK_ABC, H_INIT, ok);
    wait_out_valid(200, n);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      for (int j = 0; j < 16; j++) block_in[32*j +: 32] = $urandom;
      tick();
      if (digest_out !== DIG_ABC) n_unstable++;
      if (in_ready !== 1'b0) n_ready++;
      if (out_valid !== 1'b1) n_vlow++;
    end
    in_valid = 1'b0;
    n_checks++; if (n_unstable != 0) $display("FAIL bp_digest_stable: got %0d bad cycles want 0", n_unstable); else n_pass++;
    n_checks++; if (n_ready != 0) $display("FAIL bp_in_ready_low: got %0d bad cycles want 0", n_ready); else n_pass++;
    n_checks++; if (n_vlow != 0) $display("FAIL bp_out_valid_held: got %0d bad cycles want 0", n_vlow); else n_pass++;
    release_digest();
    send_block(BLK_EMPTY, H_INIT, ok);
    wait_out_valid(200, n);
    n_checks++; if (digest_out !== DIG_EMPTY) $display("FAIL bp_second_digest: got %h want %h", digest_out, DIG_EMPTY); else n_pass++;
    release_digest();
  endtask

  task automatic test_abort();
    bit ok; int n; int n_seen;
    send_block(BLK_ABC, H_INIT, ok);
    repeat (40) tick();
    n_checks++; if (round_idx !== 6'd40) $display("FAIL ab40_idx: got %0d want 40", round_idx); else n_pass++;
    abort = 1'b1; tick(); abort = 1'b0;
    n_checks++; if ({in_ready, busy, out_valid} !== 3'b100) $display("FAIL ab40_idle: got %b want 100", {in_ready, busy, out_valid}); else n_pass++;
    n_seen = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (out_valid !== 1'b0) n_seen++; end
    n_checks++; if (n_seen != 0) $display("FAIL ab40_no_valid: got %0d valid cycles want 0", n_seen); else n_pass++;
    n_checks++; if (digest_out !== DIG_EMPTY) $display("FAIL ab40_digest_kept: got %h want %h", digest_out, DIG_EMPTY); else n_pass++;

    send_block(BLK_ABC, H_INIT, ok);
    repeat (63) tick();
    n_checks++; if (round_idx !== 6'd63 || busy !== 1'b1) $display("FAIL ab63_idx: got %0d busy=%b want 63 busy=1", round_idx, busy); else n_pass++;
    abort = 1'b1; tick(); abort = 1'b0;
    n_seen = 0;
    for (int i = 0; i < 10; i++) begin if (out_valid !== 1'b0) n_seen++; tick(); end
    n_checks++; if (n_seen != 0 || in_ready !== 1'b1) $display("FAIL ab63_no_valid: got %0d valid ready=%b want 0 ready=1", n_seen, in_ready); else n_pass++;

    send_block(BLK_ABC, H_INIT, ok);
    repeat (64) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    n_seen = 0;
    for (int i = 0; i < 10; i++) begin if (out_valid !== 1'b0) n_seen++; tick(); end
    n_checks++; if (n_seen != 0 || digest_out !== DIG_EMPTY) $display("FAIL ab_add_cancel: got %0d valid digest %h want 0 %h", n_seen, digest_out, DIG_EMPTY); else n_pass++;

    abort = 1'b1;
    send_block(BLK_ABC, H_INIT, ok);
    n_checks++; if (busy !== 1'b1) $display("FAIL ab_idle_ignored: got busy %b want 1", busy); else n_pass++;
    abort = 1'b0;
    wait_out_valid(200, n);
    abort = 1'b1; tick(); abort = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || digest_out !== DIG_ABC) $display("FAIL ab_done_ignored: got valid=%b %h want 1 %h", out_valid, digest_out, DIG_ABC); else n_pass++;
    release_digest();
  endtask

  task automatic test_back_to_back();
    bit ok; bit got1; bit prev_ready; int t_out1; int t_acc2; int n2;
    logic [0:255] h1; logic [0:255] d1;
    h1 = ref_compress(H_INIT, BLK_TWO1);
    got1 = 1'b0; t_out1 = -1; t_acc2 = -1; d1 = 256'h0;
    out_ready = 1'b1;
    send_block(BLK_TWO1, H_INIT, ok);
    block_in = BLK_TWO2; hash_in = h1; in_valid = 1'b1;
    prev_ready = (in_ready === 1'b1);
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (out_valid === 1'b1 && !got1) begin got1 = 1'b1; t_out1 = k; d1 = digest_out; end
      if (prev_ready && in_ready === 1'b0) begin t_acc2 = k; break; end
      prev_ready = (in_ready === 1'b1);
    end
    in_valid = 1'b0;
    n_checks++; if (t_out1 != 65) $display("FAIL b2b_latency1: got %0d want 65", t_out1); else n_pass++;
    n_checks++; if (d1 !== h1) $display("FAIL b2b_digest1: got %h want %h", d1, h1); else n_pass++;
    n_checks++; if (t_acc2 != 67) $display("FAIL b2b_spacing: got %0d want 67", t_acc2); else n_pass++;
    wait_out_valid(200, n2);
    n_checks++; if (n2 != 65) $display("FAIL b2b_latency2: got %0d want 65", n2); else n_pass++;
    n_checks++; if (digest_out !== DIG_TWO) $display("FAIL b2b_digest2: got %h want %h", digest_out, DIG_TWO); else n_pass++;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    bit ok; int n; logic [0:511] blk; logic [0:255] hv; logic [0:255] exp_d;
    for (int it = 0; it < 6; it++) begin
      for (int j = 0; j < 16; j++) blk[32*j +: 32] = $urandom;
      for (int j = 0; j < 8; j++) hv[32*j +: 32] = $urandom;
      exp_d = ref_compress(hv, blk);
      send_block(blk, hv, ok);
      for (int j = 0; j < 16; j++) block_in[32*j +: 32] = $urandom;
      in_valid = 1'b1;
      wait_out_valid(200, n);
      repeat ($urandom_range(0, 4)) tick();
      in_valid = 1'b0;
      n_checks++; if (digest_out !== exp_d || n != 65) $display("FAIL rand_digest_%0d: got %h n=%0d want %h n=65", it, digest_out, n, exp_d); else n_pass++;
      release_digest();
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    block_in = 512'h0; hash_in = 256'h0;
    test_reset();
    test_abc();
    test_empty();
    test_reset_midround();
    test_back_pressure();
    test_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion want finish before 1000000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sha256_round_sequencer.md
# sha256_round_sequencer

Iterative SHA-256 compression engine controller. It accepts one 512-bit message block and a 256-bit chaining state over a valid/ready handshake, then drives the team's `choice`/`majority` bit-select functions through 64 rounds, one round per clock. It expands the message schedule on the fly, performs the final chaining addition and presents the digest on a held valid/ready output. It sits between the block-header formatter and the nonce/target comparator in the miner pipeline.

## Interface
- `NUM_ROUNDS`, default 64: rounds executed, legal 1..64. Values below 64 are for reduced-round debug only and are not SHA-256 compliant.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: `block_in`/`hash_in` valid.
- `in_ready` out 1: sequencer can accept a block.
- `block_in` in [0:511]: message block; word *i* = bits [32*i : 32*i+31]; bit 0 of each word is its MSB.
- `hash_in` in [0:255]: chaining state H0..H7, same packing.
- `abort` in 1: synchronous cancel of the current block.
- `out_valid` out 1: `digest_out` valid.
- `out_ready` in 1: consumer accepts the digest.
- `digest_out` out [0:255]: H0'..H7', same packing.
- `busy` out 1: high in ROUND and ADD.
- `round_idx` out 6: current round number, for debug.

## Operation
- States: IDLE, ROUND, ADD, DONE. All outputs are registered.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`:
    - capture `hash_in` into H[0..7] and into working registers a..h;
    - load `block_in` into the schedule window w[0..15];
    - `round_idx`←0; go to ROUND.
- **ROUND** (round t = `round_idx`)
  - T1 = h + Σ1(e) + choice(e,f,g) + K[t] + w[0].
  - T2 = Σ0(a) + majority(a,b,c).
  - Update: h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
  - Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25.
  - Window: shift w[i]←w[i+1]; w[15]←σ1(w[14])+w[9]+σ0(w[1])+w[0].
    - σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10.
  - All additions are modulo 2^32; carries are discarded.
  - K[0..63] is the standard SHA-256 constant ROM (K[0]=428a2f98, K[63]=c67178f2).
  - At t = `NUM_ROUNDS`-1, go to ADD; otherwise increment `round_idx`.
- **ADD**
  - `digest_out`[i] ← H[i] + working[i] (mod 2^32).
  - `out_valid`←1; go to DONE.
- **DONE**
  - Hold `digest_out` and `out_valid` stable until `out_ready`.
  - On `out_valid && out_ready`: `out_valid`←0, `in_ready`←1, go to IDLE.
- **Abort**
  - `abort` in ROUND or ADD: go to IDLE on the next edge. No `out_valid`; `digest_out` keeps its old value.
  - `abort` is ignored in IDLE and DONE.
  - `abort` has priority over the ROUND→ADD and ADD→DONE transitions.
- **Inputs while busy:** `in_valid` outside IDLE is ignored. The producer must hold `block_in`/`hash_in` until accepted.

## Timing
- **During reset:** state IDLE, `in_ready`=0, `out_valid`=0, `busy`=0, `round_idx`=0, `digest_out`=0, all internal registers 0.
- **Leaving reset:** `in_ready` rises on the first `clk` edge after `rst_n` deasserts.
- **Reset mid-operation:** when `rst_n` asserts in any state, all outputs clear immediately (asynchronously) and the in-flight block is lost.
- **Latency** (accept edge = edge 0):
  - rounds execute at edges 1..`NUM_ROUNDS`;
  - ADD at edge `NUM_ROUNDS`+1;
  - `out_valid` is high after edge `NUM_ROUNDS`+1 (edge 65 for the default).
- **Handshake timing:**
  - `in_ready` falls on the accept edge.
  - `busy` rises on the accept edge and falls on the ADD edge.
- **Throughput:** with `out_ready` tied high, DONE lasts one cycle, so a new block can be accepted every `NUM_ROUNDS`+3 cycles (67 for the default).
- **Round counter:** `round_idx` never wraps past `NUM_ROUNDS`-1. It holds its last value in ADD/DONE and resets to 0 on the next accept.

## Test plan
- **Reset:** assert `rst_n`=0 mid-ROUND at round 30.
  - Outputs clear immediately.
  - After release, `in_ready`=1 one edge later.
  - A fresh "abc" block then completes correctly.
- **"abc" block:**
  - Stimulus: block = 61626380, 14×00000000, 00000018; H = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
  - Required: `digest_out` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with `out_valid` after edge 65.
- **Empty message:**
  - Stimulus: block = 80000000, 15×00000000, same H.
  - Required: digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- **Back-pressure:**
  - Hold `out_ready`=0 for 10 cycles after `out_valid`.
  - Digest must stay stable, `in_ready`=0 throughout, and `in_valid` pulses must be ignored.
  - Release `out_ready` and accept a second block; both digests must be correct.
- **Abort:**
  - `abort`=1 at round 40: IDLE next edge, `out_valid` never rises, `in_ready`=1.
  - `abort`=1 while `round_idx`=63: `out_valid` never rises.
- **Back-to-back:**
  - Two-block message "abc…" (448-bit standard vector), with block 2 chained from block 1's digest and `out_ready` tied high.
  - Final digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
  - Accept-to-accept spacing = 67 cycles.
